// File: rtl/rf_write_scheduler.sv
// Write-port owner for the register file: round-robin ALU/MEM writeback
// arbitration, a registered write command, and a per-register pending scoreboard.
module rf_pend_bit (
  input  logic Clk,
  input  logic Reset,
  input  logic set,
  input  logic clr,
  output logic pend
);
  // A same-edge reserve beats the retiring write: a newer producer is outstanding.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)    pend <= 1'b0;
    else if (set) pend <= 1'b1;
    else if (clr) pend <= 1'b0;
  end
endmodule

module rf_write_scheduler #(
  parameter int W = 8,
  parameter int A = 2,
  parameter int N = 2**A
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         AluReq,
  input  logic [A-1:0] AluAddr,
  input  logic [W-1:0] AluData,
  output logic         AluGnt,
  input  logic         MemReq,
  input  logic [A-1:0] MemAddr,
  input  logic [W-1:0] MemData,
  output logic         MemGnt,
  input  logic         ResvEn,
  input  logic [A-1:0] ResvAddr,
  input  logic         RdEnA,
  input  logic [A-1:0] RaddrA,
  input  logic         RdEnB,
  input  logic [A-1:0] RaddrB,
  output logic         Stall,
  output logic [N-1:0] Pending,
  output logic         WriteEn,
  output logic [A-1:0] Waddr,
  output logic [W-1:0] DataIn,
  output logic [7:0]   ConflictCnt
);
  typedef struct packed {
    logic [A-1:0] addr;
    logic [W-1:0] data;
  } wr_t;

  logic   rr_ptr;
  logic   contested;
  wr_t    win;
  logic [N-1:0] set_vec, clr_vec;

  assign contested = AluReq && MemReq;
  assign AluGnt    = AluReq && (!MemReq || !rr_ptr);
  assign MemGnt    = MemReq && (!AluReq ||  rr_ptr);
  assign win       = AluGnt ? wr_t'{AluAddr, AluData} : wr_t'{MemAddr, MemData};

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      WriteEn     <= 1'b0;
      Waddr       <= '0;
      DataIn      <= '0;
      rr_ptr      <= 1'b0;
      ConflictCnt <= '0;
    end else begin
      WriteEn <= AluGnt || MemGnt;
      if (AluGnt || MemGnt) begin
        Waddr  <= win.addr;
        DataIn <= win.data;
      end
      // Pointer moves to the loser only when both sides competed.
      if (contested) begin
        rr_ptr <= AluGnt;
        if (ConflictCnt != 8'hFF) ConflictCnt <= ConflictCnt + 8'd1;
      end
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_pend
    assign set_vec[i] = ResvEn  && (ResvAddr == A'(i));
    assign clr_vec[i] = WriteEn && (Waddr    == A'(i));
    rf_pend_bit u_pend (
      .Clk  (Clk),
      .Reset(Reset),
      .set  (set_vec[i]),
      .clr  (clr_vec[i]),
      .pend (Pending[i])
    );
  end

  assign Stall = (RdEnA && Pending[RaddrA]) || (RdEnB && Pending[RaddrB]);
endmodule

// File: tb/tb_rf_write_scheduler.sv
// Bench for rf_write_scheduler: directed scenarios with literal expectations,
// then random traffic, all compared each cycle against a behavioural model.
module tb_rf_write_scheduler;
  logic       Clk = 1'b0;
  logic       Reset;
  logic       AluReq, MemReq, ResvEn, RdEnA, RdEnB;
  logic [1:0] AluAddr, MemAddr, ResvAddr, RaddrA, RaddrB;
  logic [7:0] AluData, MemData;
  logic       AluGnt, MemGnt, Stall, WriteEn;
  logic [3:0] Pending;
  logic [1:0] Waddr;
  logic [7:0] DataIn, ConflictCnt;

  rf_write_scheduler #(.W(8), .A(2)) dut (
    .Clk(Clk), .Reset(Reset),
    .AluReq(AluReq), .AluAddr(AluAddr), .AluData(AluData), .AluGnt(AluGnt),
    .MemReq(MemReq), .MemAddr(MemAddr), .MemData(MemData), .MemGnt(MemGnt),
    .ResvEn(ResvEn), .ResvAddr(ResvAddr),
    .RdEnA(RdEnA), .RaddrA(RaddrA), .RdEnB(RdEnB), .RaddrB(RaddrB),
    .Stall(Stall), .Pending(Pending),
    .WriteEn(WriteEn), .Waddr(Waddr), .DataIn(DataIn), .ConflictCnt(ConflictCnt)
  );

  always #5 Clk = ~Clk;

  int nvec = 0, nerr = 0;

  // Model state: what the scheduler must hold, in spec terms.
  bit [3:0] m_pend;
  int       m_prio;      // side that wins a tie: 1=ALU, 2=MEM
  bit       m_we;
  int       m_waddr, m_data, m_cnt;
  int       last_win;    // 0 none, 1 ALU, 2 MEM, for the cycle just finished

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int winner();
    if (AluReq && !MemReq) return 1;
    if (MemReq && !AluReq) return 2;
    if (AluReq && MemReq)  return m_prio;
    return 0;
  endfunction

  function automatic bit exp_stall();
    return (RdEnA && m_pend[RaddrA]) || (RdEnB && m_pend[RaddrB]);
  endfunction

  task automatic model_reset();
    m_pend = '0; m_prio = 1; m_we = 0; m_waddr = 0; m_data = 0; m_cnt = 0; last_win = 0;
  endtask

  task automatic model_edge();
    int w;
    if (Reset) begin model_reset(); return; end
    w = winner();
    if (m_we) m_pend[m_waddr] = 1'b0;
    if (ResvEn) m_pend[ResvAddr] = 1'b1;
    if (AluReq && MemReq) begin
      m_cnt  = (m_cnt >= 255) ? 255 : m_cnt + 1;
      m_prio = (w == 1) ? 2 : 1;
    end
    m_we = (w != 0);
    if (w == 1) begin m_waddr = AluAddr; m_data = AluData; end
    if (w == 2) begin m_waddr = MemAddr; m_data = MemData; end
    last_win = w;
  endtask

  task automatic compare();
    int w;
    w = winner();
    chk("AluGnt",      AluGnt,      (w == 1));
    chk("MemGnt",      MemGnt,      (w == 2));
    chk("Stall",       Stall,       exp_stall());
    chk("WriteEn",     WriteEn,     m_we);
    chk("Waddr",       Waddr,       m_waddr);
    chk("DataIn",      DataIn,      m_data);
    chk("Pending",     Pending,     m_pend);
    chk("ConflictCnt", ConflictCnt, m_cnt);
  endtask

  // Called at posedge+1; compares on the falling edge, then advances the model.
  task automatic step();
    #4 compare();
    @(posedge Clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    AluReq = 0; MemReq = 0; ResvEn = 0; RdEnA = 0; RdEnB = 0;
    AluAddr = 0; MemAddr = 0; ResvAddr = 0; RaddrA = 0; RaddrB = 0;
    AluData = 0; MemData = 0;
  endtask

  task automatic apply_reset();
    Reset = 1; idle_inputs(); model_reset();
    step(); step();
    Reset = 0;
  endtask

  bit [7:0] atab [4] = '{8'h11, 8'h12, 8'h13, 8'h14};
  bit [7:0] mtab [4] = '{8'h21, 8'h22, 8'h23, 8'h24};

  initial begin
    int na, nm;
    Reset = 1; idle_inputs(); model_reset();
    @(posedge Clk); @(posedge Clk); #1;
    chk("rst_WriteEn", WriteEn, 1'b0);
    chk("rst_Waddr",   Waddr,   2'd0);
    chk("rst_DataIn",  DataIn,  8'h00);
    chk("rst_Pending", Pending, 4'b0000);
    chk("rst_Cnt",     ConflictCnt, 8'd0);
    Reset = 0;

    // Reset lands right after a grant edge: the issued write is dropped.
    ResvEn = 1; ResvAddr = 2; step(); ResvEn = 0;
    AluReq = 1; AluAddr = 2; AluData = 8'h5A; step(); AluReq = 0;
    Reset = 1; #1;
    chk("midrst_WriteEn", WriteEn, 1'b0);
    chk("midrst_Pending", Pending, 4'b0000);
    model_reset(); step(); Reset = 0;
    step(); chk("postrst_WriteEn", WriteEn, 1'b0);
    step(); chk("postrst_WriteEn2", WriteEn, 1'b0);

    // Single ALU write with its reservation retiring on the write edge.
    apply_reset();
    ResvEn = 1; ResvAddr = 1; step(); ResvEn = 0;
    step(); chk("single_pend_c2", Pending, 4'b0010);
    AluReq = 1; AluAddr = 1; AluData = 8'h3C; #1;
    chk("single_gnt", AluGnt, 1'b1);
    step(); AluReq = 0;
    chk("single_we",   WriteEn, 1'b1);
    chk("single_wa",   Waddr,   2'd1);
    chk("single_data", DataIn,  8'h3C);
    chk("single_pend_c3", Pending, 4'b0010);
    step(); chk("single_pend_c4", Pending, 4'b0000);

    // Contention: ALU, MEM, ALU, MEM; each side advances to its next item once granted.
    apply_reset();
    na = 0; nm = 0;
    for (int k = 0; k < 4; k++) begin
      AluReq = 1; AluAddr = 2'(na); AluData = atab[na];
      MemReq = 1; MemAddr = 2'(3 - nm); MemData = mtab[nm];
      #1;
      chk("cont_alugnt", AluGnt, (k % 2 == 0));
      chk("cont_memgnt", MemGnt, (k % 2 == 1));
      step();
      chk("cont_we", WriteEn, 1'b1);
      chk("cont_data", DataIn, (k % 2 == 0) ? atab[na] : mtab[nm]);
      if (k % 2 == 0) na++; else nm++;
    end
    AluReq = 0; MemReq = 0;
    chk("cont_cnt", ConflictCnt, 8'd4);
    step(); chk("cont_we_off", WriteEn, 1'b0);

    // Stall against a pending register.
    apply_reset();
    ResvEn = 1; ResvAddr = 3; step(); ResvEn = 0;
    RdEnA = 1; RaddrA = 3; #1; chk("stall_hit", Stall, 1'b1);
    RdEnA = 0; #1;             chk("stall_noen", Stall, 1'b0);
    RdEnA = 1; RaddrA = 2; #1; chk("stall_miss", Stall, 1'b0);
    step(); RdEnA = 0;

    // Reserve and clear on the same edge.
    ResvEn = 1; ResvAddr = 0; step(); ResvEn = 0;
    AluReq = 1; AluAddr = 0; AluData = 8'h77; step(); AluReq = 0;
    ResvEn = 1; ResvAddr = 0; step(); ResvEn = 0;
    chk("setwins_p0", Pending[0], 1'b1);
    AluReq = 1; AluAddr = 0; AluData = 8'h88; step(); AluReq = 0;
    ResvEn = 1; ResvAddr = 2; step(); ResvEn = 0;
    chk("split_p0", Pending[0], 1'b0);
    chk("split_p2", Pending[2], 1'b1);

    // Saturation under 300 cycles of contention.
    apply_reset();
    for (int k = 0; k < 300; k++) begin
      AluReq = 1; MemReq = 1;
      if (last_win == 1 || k == 0) begin AluAddr = 2'($urandom); AluData = 8'($urandom); end
      if (last_win == 2 || k == 0) begin MemAddr = 2'($urandom); MemData = 8'($urandom); end
      #1;
      chk("sat_alt", AluGnt, (k % 2 == 0));
      step();
    end
    AluReq = 0; MemReq = 0;
    chk("sat_cnt", ConflictCnt, 8'd255);
    step(); chk("sat_hold", ConflictCnt, 8'd255);

    // Random traffic obeying the hold-until-grant handshake.
    apply_reset();
    for (int k = 0; k < 3000; k++) begin
      if (!AluReq || last_win == 1) begin
        AluReq = ($urandom_range(0, 3) != 0);
        AluAddr = 2'($urandom); AluData = 8'($urandom);
      end
      if (!MemReq || last_win == 2) begin
        MemReq = ($urandom_range(0, 2) != 0);
        MemAddr = 2'($urandom); MemData = 8'($urandom);
      end
      ResvEn = ($urandom_range(0, 2) == 0); ResvAddr = 2'($urandom);
      RdEnA = 1'($urandom); RaddrA = 2'($urandom);
      RdEnB = 1'($urandom); RaddrB = 2'($urandom);
      if (k == 1500) begin
        Reset = 1; #1;
        chk("rnd_rst_we", WriteEn, 1'b0);
        model_reset(); step(); Reset = 0; idle_inputs();
      end else begin
        step();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/rf_write_scheduler.md
Name: rf_write_scheduler

Overview:
- Owns the single write port of the 4-entry, 8-bit register file.
- Arbitrates two writeback requesters, ALU and MEM, with fair round-robin and valid/grant handshakes.
- Drives a registered write command (WriteEn/Waddr/DataIn) to the register file.
- Keeps a per-register pending scoreboard that decode uses to stall reads of registers with an outstanding producer.

Parameters:
W, 8, data path width
A, 2, register address width; register count N = 2**A (4)

Ports:
Clk  in  1  clock
Reset  in  1  asynchronous, active-high reset
AluReq  in  1  ALU requests a write; held until AluGnt
AluAddr  in  A  ALU destination register
AluData  in  W  ALU write data
AluGnt  out  1  combinational; request accepted at this edge
MemReq  in  1  MEM requests a write; held until MemGnt
MemAddr  in  A  MEM destination register
MemData  in  W  MEM write data
MemGnt  out  1  combinational; request accepted at this edge
ResvEn  in  1  decode reserves a destination register
ResvAddr  in  A  register being reserved
RdEnA  in  1  decode reads operand A
RaddrA  in  A  operand A address
RdEnB  in  1  decode reads operand B
RaddrB  in  A  operand B address
Stall  out  1  combinational; an enabled operand is pending
Pending  out  N  scoreboard bit per register
WriteEn  out  1  registered register-file write enable
Waddr  out  A  registered register-file write address
DataIn  out  W  registered register-file write data
ConflictCnt  out  8  saturating count of cycles in which both requested

Behaviour:
- Reset (async, active-high) forces:
  - WriteEn=0, Waddr=0, DataIn=0
  - Pending=0, ConflictCnt=0
  - RrPtr=0 (ALU has priority first)
  - Any accepted-but-unissued write is dropped.
- Arbitration is combinational within the cycle:
  - Only AluReq high -> AluGnt=1.
  - Only MemReq high -> MemGnt=1.
  - Both high -> grant goes to the RrPtr side (0=ALU, 1=MEM).
  - At most one grant per cycle.
- Handshake:
  - A requester holds Req/Addr/Data stable until it sees its Gnt.
  - Transfer occurs on the rising edge where Req && Gnt.
  - Req may drop only after that edge.
  - Gnt never asserts without Req.
- RrPtr updates only on a contested grant: it points to the loser. Uncontested grants leave RrPtr unchanged.
- Issue latency is 1 cycle. On the grant edge the scheduler registers:
  - WriteEn=1
  - Waddr = granted Addr
  - DataIn = granted Data

  The register file writes on the following edge. With no grant, WriteEn=0 next cycle and Waddr/DataIn hold their values.
- Sustained throughput is 1 write per cycle. Under continuous contention grants alternate ALU, MEM, ALU, ...
- Scoreboard, evaluated each edge:
  - ResvEn sets Pending[ResvAddr].
  - WriteEn=1 clears Pending[Waddr]; the clear coincides with the register-file write edge.
  - Set and clear of the same register in the same cycle: set wins (a newer producer is outstanding).
  - Set and clear of different registers both take effect.
  - A write to a non-pending register is legal and leaves Pending unchanged.
- Stall = (RdEnA && Pending[RaddrA]) || (RdEnB && Pending[RaddrB]). It uses current Pending only; there is no bypass.
- ConflictCnt increments each cycle both requests are high and saturates at 255.
- All outputs except AluGnt, MemGnt and Stall are registered.

Test Plan:
1. Reset mid-operation:
   - Stimulus: AluReq=1, AluAddr=2, AluData=0x5A; assert Reset right after the grant edge.
   - Required: WriteEn=0 immediately and Pending=0; after release WriteEn stays 0 until a new grant.
2. Single ALU write:
   - Stimulus: ResvEn with ResvAddr=1 at cycle 0; AluReq with AluAddr=1, AluData=0x3C at cycle 2.
   - Required: AluGnt=1 in cycle 2; WriteEn=1, Waddr=1, DataIn=0x3C in cycle 3; Pending=0010 through cycle 3, 0000 in cycle 4.
3. Contention fairness:
   - Stimulus: AluReq and MemReq held high for 4 cycles with distinct addresses and data.
   - Required: grants ALU, MEM, ALU, MEM in that order; WriteEn high for 4 consecutive cycles; ConflictCnt=4 (Alu requests last AluAddr/AluData only after first grant etc.).
4. Stall:
   - Stimulus: Pending[3]=1; RdEnA=1, RaddrA=3.
   - Required: Stall=1. With RdEnA=0, Stall=0. With RaddrA=2 and RdEnA=1, Stall=0.
5. Simultaneous reserve and clear:
   - Stimulus: WriteEn=1, Waddr=0 in the same cycle as ResvEn=1, ResvAddr=0.
   - Required: Pending[0]=1 after the edge.
   - Stimulus: same, with ResvAddr=2.
   - Required: Pending[0]=0 and Pending[2]=1.
6. Saturation:
   - Stimulus: both requests held high for 300 cycles.
   - Required: ConflictCnt=255 and does not wrap; grants keep alternating.
